// File: rtl/ie_defs.sv
// Shared CPU-side bus definitions: register addresses and the OAM DMA state encoding.
package ie_defs;

  localparam logic [15:0] OAM_DMA_REG = 16'h4014;
  localparam logic [15:0] OAMDATA_REG = 16'h2004;

  typedef enum logic [2:0] {IDLE, ALIGN, READ, WAIT, WRITE, DONE} dma_state_t;

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies page {page,00..FF} into OAMDATA one read/write pair per byte.
// OAM_DMA_ALIGN_EN: when defined, an odd-cycle trigger stretches ALIGN to two cycles.
module oam_dma_engine
  import ie_defs::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_page,
  input  logic        start_odd,
  input  logic [7:0]  mem_data_in,
  output logic        busy,
  output logic        stall,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        we
);

  localparam int LW        = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam int WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

  dma_state_t    state, state_nxt;
  logic [7:0]    page, idx, latch;
  logic [LW-1:0] lat_cnt;

`ifdef OAM_DMA_ALIGN_EN
  logic trig_par, align_x;
  wire  align_hold = trig_par && !align_x;
`else
  logic unused_par;
  assign unused_par = start_odd;
  wire  align_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      page    <= '0;
      idx     <= '0;
      latch   <= '0;
      lat_cnt <= '0;
`ifdef OAM_DMA_ALIGN_EN
      trig_par <= 1'b0;
      align_x  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          page <= start_page;
`ifdef OAM_DMA_ALIGN_EN
          trig_par <= start_odd;
          align_x  <= 1'b0;
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        ALIGN: align_x <= 1'b1;
`endif
        READ: begin
          lat_cnt <= '0;
          if (READ_LATENCY == 1) latch <= mem_data_in;
        end
        WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LW'(WAIT_LAST)) latch <= mem_data_in;
        end
        WRITE: if (idx != 8'hFF) idx <= idx + 8'd1;
        DONE:  idx <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    stall     = 1'b0;
    addr      = {page, idx};
    data      = latch;
    we        = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ALIGN;
      ALIGN: begin
        busy  = 1'b1;
        stall = 1'b1;
        addr  = {page, 8'h00};
        if (!align_hold) state_nxt = READ;
      end
      READ: begin
        busy      = 1'b1;
        stall     = 1'b1;
        state_nxt = (READ_LATENCY == 1) ? WRITE : WAIT;
      end
      WAIT: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (lat_cnt == LW'(WAIT_LAST)) state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        stall     = 1'b1;
        addr      = OAMDATA_REG;
        we        = 1'b1;
        state_nxt = (idx == 8'hFF) ? DONE : READ;
      end
      DONE: begin
        stall     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// CPU memory bus arbiter: passes the core through, or hands the bus to OAM DMA on a $4014 write.
// OAM_DMA_ALIGN_EN (optional): odd-cycle DMA starts take one extra alignment cycle.
module cpu_bus_arbiter
  import ie_defs::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_write_en,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_write_en,
  input  logic [7:0]  mem_data_in,
  output logic        dma_busy
);

  logic        parity, trigger;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        dma_we;

  always_ff @(posedge clk) begin
    if (rst) parity <= 1'b0;
    else     parity <= ~parity;
  end

  // the triggering write itself still goes out on the bus this cycle
  assign trigger = cpu_write_en && (cpu_addr == OAM_DMA_REG) && !cpu_stall;

  oam_dma_engine #(.READ_LATENCY(READ_LATENCY)) u_dma (
    .clk         (clk),
    .rst         (rst),
    .start       (trigger),
    .start_page  (cpu_data_out),
    .start_odd   (parity),
    .mem_data_in (mem_data_in),
    .busy        (dma_busy),
    .stall       (cpu_stall),
    .addr        (dma_addr),
    .data        (dma_data),
    .we          (dma_we)
  );

  assign cpu_data_in  = mem_data_in;
  assign mem_addr     = dma_busy ? dma_addr : cpu_addr;
  assign mem_data_out = dma_busy ? dma_data : cpu_data_out;
  assign mem_write_en = dma_busy ? dma_we   : cpu_write_en;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench: instance 0 at READ_LATENCY=2, instance 1 at READ_LATENCY=1; scoreboard of OAMDATA writes.
module tb_cpu_bus_arbiter;

  typedef struct {
    int          inst;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk, rst;
  logic [15:0] cpu_addr [2];
  logic [7:0]  cpu_data_out [2];
  logic        cpu_we [2];
  logic [7:0]  cpu_data_in [2];
  logic        cpu_stall [2];
  logic [15:0] mem_addr [2];
  logic [7:0]  mem_data_out [2];
  logic        mem_we [2];
  logic [7:0]  mem_data_in [2];
  logic        dma_busy [2];
  logic [15:0] addr_q0;

  exp_t        sb[$];
  int          total, bad;
  int          cyc;
  int          stall_cnt [2];
  int          wr_cnt [2];
  logic [15:0] rd_addr [2];
  logic        zero_hit [2];
  int          stall_base;

  cpu_bus_arbiter #(.READ_LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr[0]), .cpu_data_out(cpu_data_out[0]),
    .cpu_write_en(cpu_we[0]), .cpu_data_in(cpu_data_in[0]), .cpu_stall(cpu_stall[0]),
    .mem_addr(mem_addr[0]), .mem_data_out(mem_data_out[0]), .mem_write_en(mem_we[0]),
    .mem_data_in(mem_data_in[0]), .dma_busy(dma_busy[0])
  );

  cpu_bus_arbiter #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr[1]), .cpu_data_out(cpu_data_out[1]),
    .cpu_write_en(cpu_we[1]), .cpu_data_in(cpu_data_in[1]), .cpu_stall(cpu_stall[1]),
    .mem_addr(mem_addr[1]), .mem_data_out(mem_data_out[1]), .mem_write_en(mem_we[1]),
    .mem_data_in(mem_data_in[1]), .dma_busy(dma_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory image: page $02 holds byte i at $0200+i, other pages are address-scrambled
  function automatic logic [7:0] memf(input logic [15:0] a);
    return (a[15:8] == 8'h02) ? a[7:0] : (a[7:0] ^ a[15:8]);
  endfunction

  always @(posedge clk) addr_q0 <= mem_addr[0];
  always_comb begin
    mem_data_in[0] = memf(addr_q0);
    mem_data_in[1] = memf(mem_addr[1]);
  end

  // cycle counter whose LSB equals the DUT parity flop
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_stall(input int rl, input bit odd);
    int a;
    a = 0;
`ifdef OAM_DMA_ALIGN_EN
    a = odd ? 1 : 0;
`endif
    return 1 + a + 256 * (rl + 1) + 1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (cpu_stall[i]) stall_cnt[i]++;
      if (dma_busy[i] && !mem_we[i]) rd_addr[i] = mem_addr[i];
      if (dma_busy[i] && mem_addr[i] == 16'h0000) zero_hit[i] = 1'b1;
      if (dma_busy[i] && mem_we[i] && mem_addr[i] == 16'h2004) begin
        wr_cnt[i]++;
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_inst", i, e.inst);
          chk("rd_addr", rd_addr[i], e.addr);
          chk("wr_data", mem_data_out[i], e.data);
        end
      end
    end
  end

  task automatic trigger(input int inst, input logic [7:0] page, input bit odd, output int exp);
    @(negedge clk); #1;
    if (cyc[0] != odd) begin @(negedge clk); #1; end
    cpu_addr[inst]     = 16'h4014;
    cpu_data_out[inst] = page;
    cpu_we[inst]       = 1'b1;
    #1;
    chk("trig_pass_we", mem_we[inst], 1);
    chk("trig_pass_addr", mem_addr[inst], 16'h4014);
    for (int i = 0; i < 256; i++)
      sb.push_back('{inst, {page, 8'(i)}, memf({page, 8'(i)})});
    exp        = exp_stall(inst == 0 ? 2 : 1, odd);
    stall_base = stall_cnt[inst];
    @(posedge clk); #1;
    cpu_we[inst]   = 1'b0;
    cpu_addr[inst] = 16'h0100;
  endtask

  task automatic wait_done(input int inst, input int exp);
    int n;
    n = 0;
    while (cpu_stall[inst] && n < 3000) begin @(negedge clk); #1; n++; end
    chk("stall_timeout", cpu_stall[inst], 0);
    chk("stall_cycles", stall_cnt[inst] - stall_base, exp);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int exp, w, n, hits;
    total = 0; bad = 0;
    stall_cnt = '{0, 0}; wr_cnt = '{0, 0};
    rd_addr = '{16'h0, 16'h0}; zero_hit = '{1'b0, 1'b0};
    stall_base = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cpu_addr[i] = 16'h0; cpu_data_out[i] = 8'h0; cpu_we[i] = 1'b0;
    end
    cpu_addr[0] = 16'h1234;

    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_stall", cpu_stall[0], 0);
    chk("rst_busy", dma_busy[0], 0);
    chk("rst_pass_addr", mem_addr[0], 16'h1234);
    chk("rst_busy1", dma_busy[1], 0);
    rst = 1'b0;

    // 2: even trigger, page $02
    w = wr_cnt[0];
    trigger(0, 8'h02, 1'b0, exp);
    chk("t2_busy", dma_busy[0], 1);
    wait_done(0, exp);
    chk("t2_writes", wr_cnt[0] - w, 256);

    // 3: odd trigger
    w = wr_cnt[0];
    trigger(0, 8'h02, 1'b1, exp);
    wait_done(0, exp);
    chk("t3_writes", wr_cnt[0] - w, 256);

    // 4: reset after the 128th OAMDATA write
    w = wr_cnt[0];
    trigger(0, 8'h03, 1'b0, exp);
    n = 0;
    while (wr_cnt[0] - w < 128 && n < 2000) begin @(negedge clk); #1; n++; end
    chk("t4_reach128", wr_cnt[0] - w, 128);
    rst = 1'b1;
    sb.delete();
    cpu_addr[0] = 16'h0ABC;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_stall", cpu_stall[0], 0);
    chk("t4_busy", dma_busy[0], 0);
    chk("t4_pass_addr", mem_addr[0], 16'h0ABC);
    chk("t4_pass_we", mem_we[0], 0);
    hits = 0;
    repeat (600) begin @(negedge clk); #1; if (dma_busy[0] || cpu_stall[0]) hits++; end
    chk("t4_quiet", hits, 0);
    chk("t4_no_more_wr", wr_cnt[0] - w, 128);

    // 5: $4014 while stalled, $4015 while idle
    w = wr_cnt[0];
    trigger(0, 8'h04, 1'b0, exp);
    repeat (100) @(negedge clk);
    #1;
    cpu_addr[0] = 16'h4014; cpu_data_out[0] = 8'h55; cpu_we[0] = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0100;
    wait_done(0, exp);
    chk("t5_writes", wr_cnt[0] - w, 256);
    hits = 0;
    repeat (20) begin @(negedge clk); #1; if (dma_busy[0] || cpu_stall[0]) hits++; end
    chk("t5_no_retrig", hits, 0);
    cpu_addr[0] = 16'h4015; cpu_data_out[0] = 8'h09; cpu_we[0] = 1'b1;
    #1;
    chk("t5_4015_we", mem_we[0], 1);
    chk("t5_4015_addr", mem_addr[0], 16'h4015);
    @(posedge clk); #1;
    cpu_we[0] = 1'b0;
    hits = 0;
    repeat (10) begin @(negedge clk); #1; if (dma_busy[0] || cpu_stall[0]) hits++; end
    chk("t5_4015_quiet", hits, 0);

    // 6: page $FF at READ_LATENCY=1
    w = wr_cnt[1];
    trigger(1, 8'hFF, 1'b1, exp);
    wait_done(1, exp);
    chk("t6_writes", wr_cnt[1] - w, 256);
    chk("t6_last_rd", rd_addr[1], 16'hFFFF);
    chk("t6_no_0000", zero_hit[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
